// File: rtl/cache_mem_arbiter_if.sv
// Bundle of I-cache, D-cache and memory-side line channels around the arbiter.
// The master modport is the arbiter's view; slave is the caches/memory view.
interface cache_mem_arbiter_if #(
  parameter int ADDR_WIDTH      = 32,
  parameter int CACHE_LINE_SIZE = 256
);
  // I-cache channel
  logic                       i_strobe;
  logic [ADDR_WIDTH-1:0]      i_addr;
  logic                       i_done;
  logic [CACHE_LINE_SIZE-1:0] i_datain;
  // D-cache channel
  logic                       d_strobe;
  logic [ADDR_WIDTH-1:0]      d_addr;
  logic                       d_rw;
  logic [CACHE_LINE_SIZE-1:0] d_dataout;
  logic                       d_done;
  logic [CACHE_LINE_SIZE-1:0] d_datain;
  // Memory master channel
  logic                       m_strobe;
  logic [ADDR_WIDTH-1:0]      m_addr;
  logic                       m_rw;
  logic [CACHE_LINE_SIZE-1:0] m_dataout;
  logic                       m_done;
  logic [CACHE_LINE_SIZE-1:0] m_datain;

  modport master (
    input  i_strobe, i_addr, d_strobe, d_addr, d_rw, d_dataout, m_done, m_datain,
    output i_done, i_datain, d_done, d_datain, m_strobe, m_addr, m_rw, m_dataout
  );

  modport slave (
    output i_strobe, i_addr, d_strobe, d_addr, d_rw, d_dataout, m_done, m_datain,
    input  i_done, i_datain, d_done, d_datain, m_strobe, m_addr, m_rw, m_dataout
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory master between the I-cache
// and D-cache. Requests are latched per port, one memory transaction is in
// flight at a time, and the returned line plus a done pulse go back to the
// port that owned the grant.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int CACHE_LINE_SIZE = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_mem_arbiter_if.master  bus,
  output logic                 busy,
  output logic                 grant_d
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                     state, state_nxt;
  logic                       grant_nxt;   // grant_d doubles as last_grant

  logic                       i_pend, d_pend;
  logic [ADDR_WIDTH-1:0]      i_addr_q, d_addr_q;
  logic                       d_rw_q;
  logic [CACHE_LINE_SIZE-1:0] d_wline_q;
  logic [CACHE_LINE_SIZE-1:0] i_ret_q, d_ret_q;

  logic i_clr, d_clr, i_take, d_take;

  // Pending is cleared at the end of the granted port's RESP cycle; a strobe
  // in that same cycle is accepted and wins over the clear.
  assign i_clr  = (state == RESP) && !grant_d;
  assign d_clr  = (state == RESP) &&  grant_d;
  assign i_take = bus.i_strobe && (!i_pend || i_clr);
  assign d_take = bus.d_strobe && (!d_pend || d_clr);

  // Request capture for both cache ports.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (!rst_n) begin
      i_pend    <= 1'b0;
      d_pend    <= 1'b0;
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      d_rw_q    <= 1'b0;
      d_wline_q <= '0;
    end else begin
      if (i_take) begin
        i_pend   <= 1'b1;
        i_addr_q <= bus.i_addr;
      end else if (i_clr) begin
        i_pend   <= 1'b0;
      end
      if (d_take) begin
        d_pend    <= 1'b1;
        d_addr_q  <= bus.d_addr;
        d_rw_q    <= bus.d_rw;
        d_wline_q <= bus.d_dataout;
      end else if (d_clr) begin
        d_pend    <= 1'b0;
      end
    end
  end

  // State and grant-owner register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant_d <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant_d <= grant_nxt;
    end
  end

  // Next-state and round-robin grant decision.
  always_comb begin
    // NOTE: defaults first, so no path leaves a variable unassigned and no
    // latch is inferred.
    state_nxt = state;
    grant_nxt = grant_d;
    unique case (state)
      IDLE: begin
        if (i_pend || d_pend) begin
          state_nxt = ISSUE;
          grant_nxt = (i_pend && d_pend) ? !grant_d : d_pend;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT:  if (bus.m_done) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Return-line capture; m_done is only honoured in WAIT, and write-backs
  // leave the D return line untouched.
  always_ff @(posedge clk) begin
    // NOTE: the return lines are visible outputs with a defined reset value,
    // so they are reset even though they are wide.
    if (!rst_n) begin
      i_ret_q <= '0;
      d_ret_q <= '0;
    end else if (state == WAIT && bus.m_done) begin
      if (!grant_d)     i_ret_q <= bus.m_datain;
      else if (!d_rw_q) d_ret_q <= bus.m_datain;
    end
  end

  assign busy          = (state != IDLE);
  assign bus.m_strobe  = (state == ISSUE);
  assign bus.m_addr    = (state == IDLE) ? '0 : (grant_d ? d_addr_q : i_addr_q);
  assign bus.m_rw      = busy && grant_d && d_rw_q;
  assign bus.m_dataout = bus.m_rw ? d_wline_q : '0;
  assign bus.i_done    = (state == RESP) && !grant_d;
  assign bus.d_done    = (state == RESP) &&  grant_d;
  assign bus.i_datain  = i_ret_q;
  assign bus.d_datain  = d_ret_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter.
module tb_cache_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst_n;
  logic busy, grant_d;

  cache_mem_arbiter_if #(.ADDR_WIDTH(AW), .CACHE_LINE_SIZE(LW)) bus ();

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .CACHE_LINE_SIZE(LW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .grant_d (grant_d)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;
  int n_idone  = 0;
  int n_ddone  = 0;
  int n_mstb   = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock; outputs are sampled on the falling edge and pulse counters updated.
  task automatic tick();
    @(negedge clk);
    if (bus.i_done)   n_idone++;
    if (bus.d_done)   n_ddone++;
    if (bus.m_strobe) n_mstb++;
  endtask

  task automatic idle_inputs();
    bus.i_strobe  = 1'b0;
    bus.i_addr    = '0;
    bus.d_strobe  = 1'b0;
    bus.d_addr    = '0;
    bus.d_rw      = 1'b0;
    bus.d_dataout = '0;
    bus.m_done    = 1'b0;
    bus.m_datain  = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic req_i(input logic [AW-1:0] a);
    bus.i_strobe = 1'b1;
    bus.i_addr   = a;
    tick();
    bus.i_strobe = 1'b0;
  endtask

  task automatic req_d(input logic [AW-1:0] a, input logic rw, input logic [LW-1:0] line);
    bus.d_strobe  = 1'b1;
    bus.d_addr    = a;
    bus.d_rw      = rw;
    bus.d_dataout = line;
    tick();
    bus.d_strobe  = 1'b0;
  endtask

  // Memory responder: waits for m_strobe, checks the request and its stability
  // through WAIT, then pulses m_done lat cycles after the strobe cycle.
  // Returns positioned in the RESP cycle.
  task automatic serve(input int lat, input logic [LW-1:0] rdata,
                       input logic [AW-1:0] exp_addr, input logic exp_rw,
                       input logic [LW-1:0] exp_dout, input logic exp_gd,
                       output int waited);
    waited = 0;
    while (!bus.m_strobe && waited < 20) begin
      tick();
      waited++;
    end
    if (!bus.m_strobe) begin
      check("m_strobe_timeout", LW'(1'b0), LW'(1'b1));
      return;
    end
    check("m_addr",    LW'(bus.m_addr), LW'(exp_addr));
    check("m_rw",      LW'(bus.m_rw),   LW'(exp_rw));
    check("m_dataout", bus.m_dataout,   exp_dout);
    check("grant_d",   LW'(grant_d),    LW'(exp_gd));
    tick();
    check("m_strobe_one_cycle", LW'(bus.m_strobe), LW'(1'b0));
    for (int k = 1; k < lat; k++) begin
      check("wait_addr",    LW'(bus.m_addr), LW'(exp_addr));
      check("wait_rw",      LW'(bus.m_rw),   LW'(exp_rw));
      check("wait_dataout", bus.m_dataout,   exp_dout);
      tick();
    end
    bus.m_done   = 1'b1;
    bus.m_datain = rdata;
    tick();
    bus.m_done   = 1'b0;
    bus.m_datain = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int w;
    int base_i, base_d, base_s;
    logic [LW-1:0] line_a5, line_1234, line_ff;
    line_a5   = {32{8'hA5}};
    line_1234 = {16{16'h1234}};
    line_ff   = {32{8'hFF}};

    // Reset held for 3 cycles with random inputs.
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.i_strobe  = 1'($urandom);
      bus.i_addr    = $urandom;
      bus.d_strobe  = 1'($urandom);
      bus.d_addr    = $urandom;
      bus.d_rw      = 1'($urandom);
      bus.d_dataout = {8{$urandom}};
      bus.m_done    = 1'($urandom);
      bus.m_datain  = {8{$urandom}};
      tick();
    end
    check("rst_i_done",    LW'(bus.i_done),   '0);
    check("rst_d_done",    LW'(bus.d_done),   '0);
    check("rst_i_datain",  bus.i_datain,      '0);
    check("rst_d_datain",  bus.d_datain,      '0);
    check("rst_m_strobe",  LW'(bus.m_strobe), '0);
    check("rst_m_addr",    LW'(bus.m_addr),   '0);
    check("rst_m_rw",      LW'(bus.m_rw),     '0);
    check("rst_m_dataout", bus.m_dataout,     '0);
    check("rst_busy",      LW'(busy),         '0);
    check("rst_grant_d",   LW'(grant_d),      '0);
    idle_inputs();
    rst_n = 1'b1;
    tick();
    n_idone = 0; n_ddone = 0; n_mstb = 0;

    // Single I request, memory replies 5 cycles after the strobe.
    req_i(32'h8000_0100);
    serve(5, line_a5, 32'h8000_0100, 1'b0, '0, 1'b0, w);
    check("i_issue_latency", LW'(w), LW'(1));
    check("i_done_pulse",   LW'(bus.i_done), LW'(1'b1));
    check("i_datain",       bus.i_datain,    line_a5);
    check("i_busy_resp",    LW'(busy),       LW'(1'b1));
    tick();
    check("i_done_cleared", LW'(bus.i_done), LW'(1'b0));
    repeat (4) tick();
    check("i_done_count",   LW'(n_idone), LW'(1));
    check("d_done_never",   LW'(n_ddone), LW'(0));
    check("m_strobe_count", LW'(n_mstb),  LW'(1));
    check("idle_busy",      LW'(busy),    LW'(1'b0));

    // D write-back; the returned line must not reach d_datain.
    req_d(32'h8000_2000, 1'b1, line_1234);
    serve(3, line_ff, 32'h8000_2000, 1'b1, line_1234, 1'b1, w);
    check("dw_d_done",   LW'(bus.d_done), LW'(1'b1));
    check("dw_i_done",   LW'(bus.i_done), LW'(1'b0));
    check("dw_d_datain", bus.d_datain,    '0);
    tick();
    check("dw_d_done_cleared", LW'(bus.d_done), LW'(1'b0));
    check("dw_m_rw_idle",      LW'(bus.m_rw),   LW'(1'b0));
    check("dw_m_dout_idle",    bus.m_dataout,   '0);

    // Simultaneous strobes straight after reset: D first, then I unprompted.
    apply_reset();
    bus.i_strobe = 1'b1; bus.i_addr = 32'h0000_0100;
    bus.d_strobe = 1'b1; bus.d_addr = 32'h0000_0200; bus.d_rw = 1'b0; bus.d_dataout = '0;
    tick();
    idle_inputs();
    serve(2, {32{8'h11}}, 32'h0000_0200, 1'b0, '0, 1'b1, w);
    check("tie0_d_done",   LW'(bus.d_done), LW'(1'b1));
    check("tie0_d_datain", bus.d_datain,    {32{8'h11}});
    serve(2, {32{8'h22}}, 32'h0000_0100, 1'b0, '0, 1'b0, w);
    check("tie0_i_done",   LW'(bus.i_done), LW'(1'b1));
    check("tie0_i_datain", bus.i_datain,    {32{8'h22}});
    tick();

    // Repeated ties after an I grant: D, I, D, I.
    for (int j = 0; j < 2; j++) begin
      bus.i_strobe = 1'b1; bus.i_addr = 32'h0000_1000 + 32'(j * 16);
      bus.d_strobe = 1'b1; bus.d_addr = 32'h0000_2000 + 32'(j * 16); bus.d_rw = 1'b0;
      tick();
      idle_inputs();
      serve(1, '0, 32'h0000_2000 + 32'(j * 16), 1'b0, '0, 1'b1, w);
      check("rr_d_done", LW'(bus.d_done), LW'(1'b1));
      serve(1, '0, 32'h0000_1000 + 32'(j * 16), 1'b0, '0, 1'b0, w);
      check("rr_i_done", LW'(bus.i_done), LW'(1'b1));
      tick();
    end

    // Tie right after a D grant goes to I first.
    req_d(32'h0000_3000, 1'b0, '0);
    serve(1, '0, 32'h0000_3000, 1'b0, '0, 1'b1, w);
    tick();
    bus.i_strobe = 1'b1; bus.i_addr = 32'h0000_3100;
    bus.d_strobe = 1'b1; bus.d_addr = 32'h0000_3200; bus.d_rw = 1'b0;
    tick();
    idle_inputs();
    serve(1, '0, 32'h0000_3100, 1'b0, '0, 1'b0, w);
    serve(1, '0, 32'h0000_3200, 1'b0, '0, 1'b1, w);
    tick();

    // Re-strobe of I during its own RESP cycle.
    base_i = n_idone;
    req_i(32'h0000_4000);
    serve(2, {32{8'h33}}, 32'h0000_4000, 1'b0, '0, 1'b0, w);
    check("rs_first_done", LW'(bus.i_done), LW'(1'b1));
    bus.i_strobe = 1'b1; bus.i_addr = 32'h0000_4040;
    tick();
    bus.i_strobe = 1'b0;
    serve(2, {32{8'h44}}, 32'h0000_4040, 1'b0, '0, 1'b0, w);
    check("rs_second_data", bus.i_datain, {32{8'h44}});
    tick();
    check("rs_done_count", LW'(n_idone - base_i), LW'(2));

    // Duplicate d_strobe while D is pending is dropped.
    base_d = n_ddone; base_s = n_mstb;
    req_d(32'h0000_5000, 1'b0, '0);
    req_d(32'h0000_5080, 1'b0, '0);
    serve(2, {32{8'h55}}, 32'h0000_5000, 1'b0, '0, 1'b1, w);
    check("dup_d_datain", bus.d_datain, {32{8'h55}});
    repeat (8) tick();
    check("dup_strobe_count", LW'(n_mstb - base_s),  LW'(1));
    check("dup_done_count",   LW'(n_ddone - base_d), LW'(1));
    check("dup_busy",         LW'(busy),             LW'(1'b0));

    // Reset during WAIT, then a late m_done.
    base_i = n_idone; base_d = n_ddone;
    req_i(32'h0000_6000);
    w = 0;
    while (!bus.m_strobe && w < 20) begin tick(); w++; end
    check("rw_m_strobe_seen", LW'(bus.m_strobe), LW'(1'b1));
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.m_done = 1'b1; bus.m_datain = {32{8'h66}};
    tick();
    bus.m_done = 1'b0; bus.m_datain = '0;
    repeat (4) tick();
    check("rw_no_i_done", LW'(n_idone - base_i), LW'(0));
    check("rw_no_d_done", LW'(n_ddone - base_d), LW'(0));
    check("rw_busy",      LW'(busy),             LW'(1'b0));
    check("rw_i_datain",  bus.i_datain,          '0);
    req_d(32'h0000_7000, 1'b0, '0);
    serve(4, {32{8'h77}}, 32'h0000_7000, 1'b0, '0, 1'b1, w);
    check("rw_fresh_d_done",   LW'(bus.d_done), LW'(1'b1));
    check("rw_fresh_d_datain", bus.d_datain,    {32{8'h77}});
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
